// File: rtl/sodor_router_pkg.sv
// Shared memory-request constants and the address-window match helper
// used by the Sodor memory router.
package sodor_router_pkg;

    // Request function: load or store.
    localparam logic M_XRD = 1'b0;
    localparam logic M_XWR = 1'b1;

    typedef logic [2:0] mem_typ_t;

    localparam mem_typ_t MT_X  = 3'd0;
    localparam mem_typ_t MT_B  = 3'd1;
    localparam mem_typ_t MT_H  = 3'd2;
    localparam mem_typ_t MT_W  = 3'd3;
    localparam mem_typ_t MT_D  = 3'd4;
    localparam mem_typ_t MT_BU = 3'd5;
    localparam mem_typ_t MT_HU = 3'd6;
    localparam mem_typ_t MT_WU = 3'd7;

    // A window matches when every address bit selected by the mask equals the base.
    function automatic logic match(
        input logic [31:0] addr,
        input logic [31:0] base,
        input logic [31:0] mask
    );
        return ((addr ^ base) & mask) == 32'h0;
    endfunction

endpackage

// File: rtl/sodor_tag_fifo.sv
// Synchronous FIFO holding the destination tag of each outstanding request.
// Supports push and pop in the same cycle; pointers carry one extra wrap bit.
module sodor_tag_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    // NOTE: tag storage is deliberately not reset; the pointers alone say which entries are live.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values;
    // combinational blocks use blocking (=).
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;
    assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/sodor_mem_router.sv
// Routes Sodor core memory requests to NUM_PORTS slaves by address window and
// returns responses in issue order using a FIFO of destination tags.
module sodor_mem_router
    import sodor_router_pkg::*;
#(
    parameter int                      NUM_PORTS    = 2,
    parameter int                      DEPTH        = 4,
    // Port 0: scratchpad window at 0x0 (256 KiB); port 1: catch-all bus at 0x80000000.
    parameter logic [NUM_PORTS*32-1:0] PORT_BASE    = {32'h8000_0000, 32'h0000_0000},
    parameter logic [NUM_PORTS*32-1:0] PORT_MASK    = {32'h0000_0000, 32'hFFFC_0000},
    parameter int                      DEFAULT_PORT = 1
) (
    input  logic                       clock,
    input  logic                       reset,

    input  logic                       io_core_req_valid,
    output logic                       io_core_req_ready,
    input  logic [31:0]                io_core_req_bits_addr,
    input  logic [31:0]                io_core_req_bits_data,
    input  logic                       io_core_req_bits_fcn,
    input  logic [2:0]                 io_core_req_bits_typ,

    output logic                       io_core_resp_valid,
    output logic [31:0]                io_core_resp_bits_data,
    output logic                       io_core_resp_err,

    output logic [NUM_PORTS-1:0]       io_slv_req_valid,
    input  logic [NUM_PORTS-1:0]       io_slv_req_ready,
    output logic [31:0]                io_slv_req_bits_addr,
    output logic [31:0]                io_slv_req_bits_data,
    output logic                       io_slv_req_bits_fcn,
    output logic [2:0]                 io_slv_req_bits_typ,

    input  logic [NUM_PORTS-1:0]       io_slv_resp_valid,
    input  logic [NUM_PORTS*32-1:0]    io_slv_resp_bits_data,

    output logic [$clog2(DEPTH):0]     io_outstanding,
    output logic                       io_proto_err
);

    // Tag NUM_PORTS is reserved for locally answered (unmapped) accesses.
    localparam int            TW      = $clog2(NUM_PORTS + 1);
    localparam logic [TW-1:0] ERR_TAG = TW'(NUM_PORTS);

    logic [TW-1:0] target;
    logic          target_ready;
    logic          accept;

    logic [TW-1:0] head_tag;
    logic          fifo_full;
    logic          fifo_empty;
    logic          head_resp_valid;
    logic [31:0]   head_resp_data;
    logic          stray_resp;
    logic          pop;

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        target = TW'(DEFAULT_PORT);
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (match(io_core_req_bits_addr, PORT_BASE[32*i +: 32], PORT_MASK[32*i +: 32])) begin
                target = TW'(i);
            end
        end
    end

    // Error targets need no slave handshake; ready never looks at the response path.
    always_comb begin
        target_ready = (target == ERR_TAG);
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (target == TW'(i)) begin
                target_ready = io_slv_req_ready[i];
            end
        end
    end

    always_comb begin
        io_slv_req_valid = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            io_slv_req_valid[i] = io_core_req_valid & ~fifo_full & (target == TW'(i));
        end
    end

    assign io_core_req_ready    = ~fifo_full & target_ready;
    assign accept               = io_core_req_valid & io_core_req_ready;

    assign io_slv_req_bits_addr = io_core_req_bits_addr;
    assign io_slv_req_bits_data = io_core_req_bits_data;
    assign io_slv_req_bits_fcn  = io_core_req_bits_fcn;
    assign io_slv_req_bits_typ  = io_core_req_bits_typ;

    sodor_tag_fifo #(
        .WIDTH (TW),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (accept),
        .push_data (target),
        .pop       (pop),
        .head      (head_tag),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (io_outstanding)
    );

    // Only the head slave may answer; anything else is dropped and flagged.
    always_comb begin
        head_resp_valid = 1'b0;
        head_resp_data  = '0;
        stray_resp      = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!fifo_empty && head_tag == TW'(i)) begin
                head_resp_valid = io_slv_resp_valid[i];
                head_resp_data  = io_slv_resp_bits_data[32*i +: 32];
            end else if (io_slv_resp_valid[i]) begin
                stray_resp = 1'b1;
            end
        end
    end

    assign io_core_resp_err       = ~fifo_empty & (head_tag == ERR_TAG);
    assign io_core_resp_valid     = io_core_resp_err | head_resp_valid;
    assign io_core_resp_bits_data = head_resp_data;
    assign pop                    = io_core_resp_valid;

    always_ff @(posedge clock) begin
        if (reset) begin
            io_proto_err <= 1'b0;
        end else if (stray_resp) begin
            io_proto_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sodor_mem_router.sv
// Directed scoreboard bench for sodor_mem_router: a default two-port instance
// plus a three-port instance whose unmapped accesses answer with an error.
module tb_sodor_mem_router;
    import sodor_router_pkg::*;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } resp_t;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    resp_t       exp_q[$];
    logic [31:0] owed0[$];
    logic [31:0] owed1[$];

    // Instance A: default two-port map.
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic        req_fcn;
    logic [2:0]  req_typ;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_err;
    logic [1:0]  slv_req_valid;
    logic [1:0]  slv_req_ready;
    logic [31:0] slv_addr;
    logic [31:0] slv_data;
    logic        slv_fcn;
    logic [2:0]  slv_typ;
    logic [1:0]  slv_resp_valid;
    logic [63:0] slv_resp_data;
    logic [2:0]  outstanding;
    logic        proto_err;

    sodor_mem_router #(
        .NUM_PORTS    (2),
        .DEPTH        (4),
        .PORT_BASE    ({32'h8000_0000, 32'h0000_0000}),
        .PORT_MASK    ({32'h0000_0000, 32'hFFFC_0000}),
        .DEFAULT_PORT (1)
    ) u_dut (
        .clock                  (clock),
        .reset                  (reset),
        .io_core_req_valid      (req_valid),
        .io_core_req_ready      (req_ready),
        .io_core_req_bits_addr  (req_addr),
        .io_core_req_bits_data  (req_data),
        .io_core_req_bits_fcn   (req_fcn),
        .io_core_req_bits_typ   (req_typ),
        .io_core_resp_valid     (resp_valid),
        .io_core_resp_bits_data (resp_data),
        .io_core_resp_err       (resp_err),
        .io_slv_req_valid       (slv_req_valid),
        .io_slv_req_ready       (slv_req_ready),
        .io_slv_req_bits_addr   (slv_addr),
        .io_slv_req_bits_data   (slv_data),
        .io_slv_req_bits_fcn    (slv_fcn),
        .io_slv_req_bits_typ    (slv_typ),
        .io_slv_resp_valid      (slv_resp_valid),
        .io_slv_resp_bits_data  (slv_resp_data),
        .io_outstanding         (outstanding),
        .io_proto_err           (proto_err)
    );

    // Instance B: three ports, unmapped addresses answered locally with an error.
    logic        req_valid3;
    logic        req_ready3;
    logic [31:0] req_addr3;
    logic        resp_valid3;
    logic [31:0] resp_data3;
    logic        resp_err3;
    logic [2:0]  slv_req_valid3;
    logic [31:0] slv_addr3;
    logic [31:0] slv_data3;
    logic        slv_fcn3;
    logic [2:0]  slv_typ3;
    logic [2:0]  slv_resp_valid3;
    logic [95:0] slv_resp_data3;
    logic [2:0]  outstanding3;
    logic        proto_err3;

    sodor_mem_router #(
        .NUM_PORTS    (3),
        .DEPTH        (4),
        .PORT_BASE    ({32'h1000_0000, 32'h8000_0000, 32'h0000_0000}),
        .PORT_MASK    ({32'hF000_0000, 32'hF000_0000, 32'hFFFC_0000}),
        .DEFAULT_PORT (3)
    ) u_dut3 (
        .clock                  (clock),
        .reset                  (reset),
        .io_core_req_valid      (req_valid3),
        .io_core_req_ready      (req_ready3),
        .io_core_req_bits_addr  (req_addr3),
        .io_core_req_bits_data  (32'h0),
        .io_core_req_bits_fcn   (M_XRD),
        .io_core_req_bits_typ   (MT_W),
        .io_core_resp_valid     (resp_valid3),
        .io_core_resp_bits_data (resp_data3),
        .io_core_resp_err       (resp_err3),
        .io_slv_req_valid       (slv_req_valid3),
        .io_slv_req_ready       (3'b111),
        .io_slv_req_bits_addr   (slv_addr3),
        .io_slv_req_bits_data   (slv_data3),
        .io_slv_req_bits_fcn    (slv_fcn3),
        .io_slv_req_bits_typ    (slv_typ3),
        .io_slv_resp_valid      (slv_resp_valid3),
        .io_slv_resp_bits_data  (slv_resp_data3),
        .io_outstanding         (outstanding3),
        .io_proto_err           (proto_err3)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change just after the rising edge; outputs are sampled on the falling edge.
    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        @(negedge clock);
    endtask

    task automatic drive_req(input logic [31:0] addr, input logic fcn, input logic [31:0] wdata,
                             input mem_typ_t typ);
        req_valid = 1'b1;
        req_addr  = addr;
        req_fcn   = fcn;
        req_data  = wdata;
        req_typ   = typ;
    endtask

    // Record the response the core must eventually see and what the slave owes.
    task automatic expect_push(input int port, input logic [31:0] rdata);
        exp_q.push_back('{data: rdata, err: 1'b0});
        if (port == 0) owed0.push_back(rdata);
        else           owed1.push_back(rdata);
    endtask

    task automatic slave_respond(input int port);
        slv_resp_valid[port] = 1'b1;
        if (port == 0) slv_resp_data[31:0]  = owed0.pop_front();
        else           slv_resp_data[63:32] = owed1.pop_front();
    endtask

    task automatic expect_resp(input string tag);
        resp_t e;
        check({tag, "_valid"}, resp_valid, 1);
        check({tag, "_sb_nonempty"}, exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check({tag, "_data"}, resp_data, e.data);
            check({tag, "_err"}, resp_err, e.err);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset          = 1'b1;
        req_valid      = 1'b0;
        req_addr       = '0;
        req_data       = '0;
        req_fcn        = M_XRD;
        req_typ        = MT_W;
        slv_req_ready  = 2'b11;
        slv_resp_valid = '0;
        slv_resp_data  = '0;
        req_valid3      = 1'b0;
        req_addr3       = '0;
        slv_resp_valid3 = '0;
        slv_resp_data3  = '0;

        // Reset state.
        next_cycle();
        next_cycle();
        settle();
        check("rst_outstanding", outstanding, 0);
        check("rst_proto_err", proto_err, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_err", resp_err, 0);
        check("rst_resp_data", resp_data, 0);
        check("rst_slv_valid", slv_req_valid, 0);
        check("rst_slv_valid3", slv_req_valid3, 0);
        next_cycle();
        reset = 1'b0;

        // Single load to port 1, answered three cycles later.
        drive_req(32'h8000_0010, M_XRD, 32'h0, MT_W);
        settle();
        check("ld_slv_valid", slv_req_valid, 2'b10);
        check("ld_ready", req_ready, 1);
        check("ld_bcast_addr", slv_addr, 32'h8000_0010);
        expect_push(1, 32'hDEAD_BEEF);
        next_cycle();
        req_valid = 1'b0;
        settle();
        check("ld_outstanding_1", outstanding, 1);
        check("ld_no_early_resp", resp_valid, 0);
        next_cycle();
        next_cycle();
        slave_respond(1);
        settle();
        expect_resp("ld_resp");
        check("ld_outstanding_before_pop", outstanding, 1);
        next_cycle();
        slv_resp_valid = '0;
        settle();
        check("ld_outstanding_0", outstanding, 0);
        check("ld_proto_err", proto_err, 0);

        // Back-to-back loads; slave 1 answers out of order and is dropped.
        next_cycle();
        drive_req(32'h0000_0100, M_XRD, 32'h0, MT_W);
        settle();
        check("b2b_port0_valid", slv_req_valid, 2'b01);
        expect_push(0, 32'h1111_0000);
        next_cycle();
        drive_req(32'h8000_0000, M_XRD, 32'h0, MT_W);
        slv_resp_valid     = 2'b10;
        slv_resp_data[63:32] = 32'h9999_9999;
        settle();
        check("b2b_port1_valid", slv_req_valid, 2'b10);
        check("b2b_stray_not_passed", resp_valid, 0);
        expect_push(1, 32'h2222_0000);
        next_cycle();
        req_valid      = 1'b0;
        slv_resp_valid = '0;
        settle();
        check("b2b_proto_err", proto_err, 1);
        check("b2b_outstanding", outstanding, 2);
        next_cycle();
        slave_respond(0);
        settle();
        expect_resp("b2b_resp0");
        next_cycle();
        slv_resp_valid = '0;
        slave_respond(1);
        settle();
        expect_resp("b2b_resp1");
        next_cycle();
        slv_resp_valid = '0;
        settle();
        check("b2b_drained", outstanding, 0);

        // Fill all four entries with stores, then hold the fifth request.
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            drive_req(32'h8000_0100 + 32'(4 * k), M_XWR, 32'(k), MT_W);
            settle();
            check("fill_ready", req_ready, 1);
            expect_push(1, 32'hA000_0000 + 32'(k));
        end
        next_cycle();
        drive_req(32'h8000_0110, M_XWR, 32'h5, MT_W);
        slave_respond(1);
        settle();
        check("full_outstanding", outstanding, 4);
        check("full_ready_low", req_ready, 0);
        check("full_no_slv_valid", slv_req_valid, 2'b00);
        expect_resp("full_resp");
        next_cycle();
        slv_resp_valid = '0;
        slave_respond(1);
        settle();
        check("refill_outstanding", outstanding, 3);
        check("refill_ready", req_ready, 1);
        check("refill_slv_valid", slv_req_valid, 2'b10);
        expect_resp("refill_resp");
        expect_push(1, 32'hA000_0004);
        next_cycle();
        req_valid      = 1'b0;
        slv_resp_valid = '0;
        settle();
        check("pushpop_outstanding", outstanding, 3);
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            slave_respond(1);
            settle();
            expect_resp("drain_resp");
            next_cycle();
            slv_resp_valid = '0;
        end
        settle();
        check("drain_outstanding", outstanding, 0);

        // Three-port instance: error tag waits behind a slave tag.
        next_cycle();
        req_valid3 = 1'b1;
        req_addr3  = 32'h1000_0004;
        settle();
        check("u3_port2_valid", slv_req_valid3, 3'b100);
        next_cycle();
        req_addr3 = 32'h4000_0000;
        settle();
        check("u3_err_no_slv_valid", slv_req_valid3, 3'b000);
        check("u3_err_ready", req_ready3, 1);
        check("u3_no_resp_yet", resp_valid3, 0);
        next_cycle();
        req_valid3 = 1'b0;
        settle();
        check("u3_err_waits", resp_valid3, 0);
        check("u3_outstanding", outstanding3, 2);
        next_cycle();
        slv_resp_valid3        = 3'b100;
        slv_resp_data3[95:64]  = 32'h0000_0033;
        settle();
        check("u3_slv_resp_valid", resp_valid3, 1);
        check("u3_slv_resp_data", resp_data3, 32'h33);
        check("u3_slv_resp_err", resp_err3, 0);
        next_cycle();
        slv_resp_valid3 = '0;
        settle();
        check("u3_err_resp_valid", resp_valid3, 1);
        check("u3_err_resp_err", resp_err3, 1);
        check("u3_err_resp_data", resp_data3, 0);
        next_cycle();
        settle();
        check("u3_drained", outstanding3, 0);
        check("u3_idle", resp_valid3, 0);
        check("u3_proto_err", proto_err3, 0);

        // Reset with three outstanding requests flushes them.
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            drive_req(32'h8000_0300 + 32'(4 * k), M_XRD, 32'h0, MT_W);
            expect_push(1, 32'hB000_0000 + 32'(k));
        end
        next_cycle();
        req_valid = 1'b0;
        settle();
        check("pre_rst_outstanding", outstanding, 3);
        exp_q.delete();
        owed1.delete();
        next_cycle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        settle();
        check("mid_rst_outstanding", outstanding, 0);
        check("mid_rst_resp_valid", resp_valid, 0);
        check("mid_rst_proto_err", proto_err, 0);
        next_cycle();
        slv_resp_valid       = 2'b10;
        slv_resp_data[63:32] = 32'h7777_7777;
        settle();
        check("post_rst_stray_dropped", resp_valid, 0);
        next_cycle();
        slv_resp_valid = '0;
        settle();
        check("post_rst_proto_err", proto_err, 1);

        // Slave 1 stalls for four cycles; the held store goes through on the first ready.
        slv_req_ready = 2'b01;
        next_cycle();
        drive_req(32'h8000_0200, M_XWR, 32'hCAFE_F00D, MT_B);
        for (int k = 0; k < 4; k++) begin
            settle();
            check("stall_ready_low", req_ready, 0);
            check("stall_slv_valid", slv_req_valid, 2'b10);
            check("stall_bcast_data", slv_data, 32'hCAFE_F00D);
            check("stall_outstanding", outstanding, 0);
            next_cycle();
        end
        slv_req_ready = 2'b11;
        settle();
        check("stall_release_ready", req_ready, 1);
        check("stall_bcast_fcn", slv_fcn, M_XWR);
        check("stall_bcast_typ", slv_typ, MT_B);
        expect_push(1, 32'h0000_0000);
        next_cycle();
        req_valid = 1'b0;
        settle();
        check("stall_outstanding_1", outstanding, 1);
        next_cycle();
        slave_respond(1);
        settle();
        expect_resp("stall_resp");
        next_cycle();
        slv_resp_valid = '0;
        settle();
        check("stall_drained", outstanding, 0);
        check("sb_empty_at_end", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
